// File: rtl/riscv_cpu_mc.sv
// Multi-cycle RV32I-subset core with a single shared req/ready memory port.
// Instructions walk FETCH/DECODE/EXEC/(MEM)/(WB); illegal or misaligned ops halt in TRAP.
module riscv_cpu_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic        trap
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = (NUM_REGS == 16) ? 4 : 5;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [2:0]      state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] ir_q, ir_nxt;
    logic [XLEN-1:0] a_q, a_nxt;
    logic [XLEN-1:0] b_q, b_nxt;
    logic [XLEN-1:0] alu_q, alu_nxt;
    logic [XLEN-1:0] mdr_q, mdr_nxt;
    logic            retire_q, retire_nxt;
    logic            trap_q, trap_nxt;

    logic [XLEN-1:0] rf [NUM_REGS];
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    // Instruction fields and immediates, decoded straight from IR
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};

    logic is_load, is_store, is_reg, is_imm, is_branch, is_jal, is_jalr, is_lui;
    logic legal, uses_rd, uses_rs1, uses_rs2, reg_bad;

    // Instruction class, legality and which register fields are architecturally used
    always_comb begin
        is_load   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
        is_store  = (opcode == OP_STORE)  && (funct3 == 3'b010);
        is_reg    = 1'b0;
        is_imm    = 1'b0;
        is_branch = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR)   && (funct3 == 3'b000);
        is_lui    = (opcode == OP_LUI);
        if (opcode == OP_REG) begin
            if (funct7 == 7'b0000000) begin
                is_reg = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                         (funct3 == 3'b110) || (funct3 == 3'b010);
            end else if (funct7 == 7'b0100000) begin
                is_reg = (funct3 == 3'b000);
            end
        end
        if (opcode == OP_IMM) begin
            is_imm = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                     (funct3 == 3'b110) || (funct3 == 3'b010);
        end
        legal    = is_load | is_store | is_reg | is_imm | is_branch | is_jal | is_jalr | is_lui;
        uses_rd  = is_load | is_reg | is_imm | is_jal | is_jalr | is_lui;
        uses_rs1 = is_load | is_store | is_reg | is_imm | is_branch | is_jalr;
        uses_rs2 = is_store | is_reg | is_branch;
        reg_bad  = (NUM_REGS == 16) &&
                   ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]));
    end

    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1[RW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2[RW-1:0]];

    logic [XLEN-1:0] op_b, alu_res, br_target, jmp_target, eff_addr, pc_plus4;
    logic            taken;

    // Datapath results used in EXEC
    always_comb begin
        op_b = is_reg ? b_q : imm_i;
        case (funct3)
            3'b000:  alu_res = (is_reg && funct7[5]) ? (a_q - b_q) : (a_q + op_b);
            3'b111:  alu_res = a_q & op_b;
            3'b110:  alu_res = a_q | op_b;
            3'b010:  alu_res = {31'b0, ($signed(a_q) < $signed(op_b))};
            default: alu_res = '0;
        endcase
        if (is_lui) begin
            alu_res = imm_u;
        end
        pc_plus4   = pc_q + 32'd4;
        br_target  = pc_q + imm_b;
        jmp_target = is_jal ? (pc_q + imm_j) : ((a_q + imm_i) & ~32'd1);
        eff_addr   = a_q + (is_store ? imm_s : imm_i);
        taken      = funct3[0] ? (a_q != b_q) : (a_q == b_q);
    end

    // Next-state, datapath updates and memory-port drive
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        ir_nxt     = ir_q;
        a_nxt      = a_q;
        b_nxt      = b_q;
        alu_nxt    = alu_q;
        mdr_nxt    = mdr_q;
        retire_nxt = 1'b0;
        trap_nxt   = trap_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_q;
        mem_wdata  = b_q;
        rf_we      = 1'b0;
        rf_wdata   = alu_q;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_nxt    = mem_rdata;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                a_nxt = rs1_val;
                b_nxt = rs2_val;
                if (!legal || reg_bad) begin
                    state_nxt = S_TRAP;
                    trap_nxt  = 1'b1;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    if (taken && (br_target[1:0] != 2'b00)) begin
                        state_nxt = S_TRAP;
                        trap_nxt  = 1'b1;
                    end else begin
                        pc_nxt     = taken ? br_target : pc_plus4;
                        retire_nxt = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end else if (is_jal || is_jalr) begin
                    if (jmp_target[1:0] != 2'b00) begin
                        state_nxt = S_TRAP;
                        trap_nxt  = 1'b1;
                    end else begin
                        alu_nxt   = pc_plus4;
                        pc_nxt    = jmp_target;
                        state_nxt = S_WB;
                    end
                end else if (is_load || is_store) begin
                    if (eff_addr[1:0] != 2'b00) begin
                        state_nxt = S_TRAP;
                        trap_nxt  = 1'b1;
                    end else begin
                        alu_nxt   = eff_addr;
                        pc_nxt    = pc_plus4;
                        state_nxt = S_MEM;
                    end
                end else begin
                    alu_nxt   = alu_res;
                    pc_nxt    = pc_plus4;
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = alu_q;
                mem_we   = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        retire_nxt = 1'b1;
                        state_nxt  = S_FETCH;
                    end else begin
                        mdr_nxt   = mem_rdata;
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                rf_wdata   = is_load ? mdr_q : alu_q;
                retire_nxt = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_TRAP;
                trap_nxt  = 1'b1;
            end
        endcase
        // A request in flight is abandoned the moment reset is seen
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            ir_q     <= ir_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            alu_q    <= alu_nxt;
            mdr_q    <= mdr_nxt;
            retire_q <= retire_nxt;
            trap_q   <= trap_nxt;
        end
    end

    // Register file is deliberately left uninitialised; x0 is never written
    always_ff @(posedge clk) begin
        if (!reset && rf_we && (rd != 5'd0)) begin
            rf[rd[RW-1:0]] <= rf_wdata;
        end
    end

    assign PC     = pc_q;
    assign retire = retire_q & ~reset;
    assign trap   = trap_q;

endmodule

// File: tb/tb_riscv_cpu_mc.sv
// Directed bench for riscv_cpu_mc: table of small programs plus a mid-fetch reset sequence.
// An RV32E instance runs alongside and is checked for the out-of-range register trap.
module tb_riscv_cpu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ready, retire, trap;
    logic [31:0] pc_e, mem_addr_e, mem_wdata_e, mem_rdata_e;
    logic        mem_req_e, mem_we_e, mem_ready_e, retire_e, trap_e;

    always #5 clk = ~clk;

    riscv_cpu_mc #(.RESET_PC(32'h0000_0100), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .PC(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire), .trap(trap)
    );

    riscv_cpu_mc #(.RESET_PC(32'h0000_0100), .NUM_REGS(16)) dut_e (
        .clk(clk), .reset(reset), .PC(pc_e),
        .mem_req(mem_req_e), .mem_we(mem_we_e), .mem_addr(mem_addr_e), .mem_wdata(mem_wdata_e),
        .mem_rdata(mem_rdata_e), .mem_ready(mem_ready_e), .retire(retire_e), .trap(trap_e)
    );

    typedef struct packed {
        logic [63:0]       name;
        logic [9:0][31:0]  prog;
        logic [7:0]        waits;
        logic [7:0]        run;
        logic [31:0]       exp_pc;
        logic              exp_trap;
        logic [7:0]        exp_nret;
        logic [7:0]        ret_k;
        logic [7:0]        ret_cyc;
        logic [1:0]        n_chk;
        logic [2:0][7:0]   chk_w;
        logic [2:0][31:0]  exp_w;
        logic              chk_e;
    } vec_t;

    logic [31:0] mem [256];
    int          waits, cnt, cyc_n, nret, ret_k, ret_cyc;
    logic        pend, sv_we;
    logic [31:0] sv_addr, sv_wdata;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vecs [6];

    function automatic logic [31:0] i_type(input int imm, input int rs1, input logic [2:0] f3,
                                           input int rd, input logic [6:0] op);
        logic [31:0] t;
        t = imm;
        return {t[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] r_type(input logic [6:0] f7, input int rs2, input int rs1,
                                           input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return i_type(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] lw(input int rd, input int imm, input int rs1);
        return i_type(imm, rs1, 3'b010, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int imm, input int rs1);
        logic [31:0] t;
        t = imm;
        return {t[11:5], 5'(rs2), 5'(rs1), 3'b010, t[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
        logic [31:0] t;
        t = imm;
        return {t[12], t[10:5], 5'(rs2), 5'(rs1), f3, t[4:1], t[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int imm);
        logic [31:0] t;
        t = imm;
        return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
        return i_type(imm, rs1, 3'b000, rd, 7'b1100111);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model for both cores; the main core sees `waits` wait states per request
    task automatic drive_mem();
        mem_ready_e = 1'b1;
        mem_rdata_e = mem[mem_addr_e[9:2]];
        if (mem_req) begin
            if (pend) begin
                chk("hold addr", mem_addr, sv_addr);
                chk("hold we", 32'(mem_we), 32'(sv_we));
                chk("hold wdata", mem_wdata, sv_wdata);
            end
            if (cnt >= waits) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                cnt  = 0;
                pend = 1'b0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                cnt++;
                pend     = 1'b1;
                sv_addr  = mem_addr;
                sv_we    = mem_we;
                sv_wdata = mem_wdata;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            cnt  = 0;
            pend = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        if (retire) begin
            nret++;
            if (nret == ret_k) ret_cyc = cyc_n;
        end
        drive_mem();
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_A5A5;
        for (int i = 0; i < 10; i++) mem[64 + i] = v.prog[i];
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
        drive_mem();
        cyc_n   = 0;
        nret    = 0;
        ret_cyc = -1;
    endtask

    task automatic run_vec(input vec_t v);
        load(v);
        waits = int'(v.waits);
        ret_k = int'(v.ret_k);
        reset = 1'b1;
        cyc();
        cyc();
        release_reset();
        repeat (int'(v.run)) cyc();
        chk($sformatf("%s pc", v.name), pc, v.exp_pc);
        chk($sformatf("%s trap", v.name), 32'(trap), 32'(v.exp_trap));
        chk($sformatf("%s retires", v.name), nret, 32'(v.exp_nret));
        chk($sformatf("%s req idle", v.name), 32'(mem_req), 32'd0);
        chk($sformatf("%s retire idle", v.name), 32'(retire), 32'd0);
        if (v.ret_k != 8'd0) chk($sformatf("%s latency", v.name), ret_cyc, 32'(v.ret_cyc));
        for (int j = 0; j < int'(v.n_chk); j++)
            chk($sformatf("%s mem[%0d]", v.name, v.chk_w[j]), mem[v.chk_w[j]], v.exp_w[j]);
        if (v.chk_e) begin
            chk($sformatf("%s e trap", v.name), 32'(trap_e), 32'd1);
            chk($sformatf("%s e pc", v.name), pc_e, 32'h0000_0108);
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_ready_e = 1'b0;
        mem_rdata_e = '0;
        waits = 0; cnt = 0; pend = 1'b0; cyc_n = 0; nret = 0; ret_k = 0; ret_cyc = -1;
        sv_we = 1'b0; sv_addr = '0; sv_wdata = '0;

        for (int i = 0; i < 6; i++) vecs[i] = '0;
        // ALU/load/store program, zero and three wait states
        vecs[0].name = "alu_ws0 ";
        vecs[0].prog[0] = addi(1, 0, 5);
        vecs[0].prog[1] = addi(2, 0, -3);
        vecs[0].prog[2] = r_type(7'b0000000, 2, 1, 3'b000, 3);
        vecs[0].prog[3] = r_type(7'b0000000, 1, 2, 3'b010, 4);
        vecs[0].prog[4] = sw(3, 8, 0);
        vecs[0].prog[5] = lw(5, 8, 0);
        vecs[0].prog[6] = sw(4, 12, 0);
        vecs[0].prog[7] = sw(5, 16, 0);
        vecs[0].run = 8'd60;  vecs[0].exp_pc = 32'h120; vecs[0].exp_trap = 1'b1;
        vecs[0].exp_nret = 8'd8; vecs[0].ret_k = 8'd6; vecs[0].ret_cyc = 8'd25;
        vecs[0].n_chk = 2'd3;
        vecs[0].chk_w[0] = 8'd2; vecs[0].exp_w[0] = 32'd2;
        vecs[0].chk_w[1] = 8'd3; vecs[0].exp_w[1] = 32'd1;
        vecs[0].chk_w[2] = 8'd4; vecs[0].exp_w[2] = 32'd2;
        vecs[1] = vecs[0];
        vecs[1].name = "alu_ws3 "; vecs[1].waits = 8'd3; vecs[1].run = 8'd100; vecs[1].ret_cyc = 8'd49;
        // beq taken, bne not taken, jal x1 +16, jalr back with bit 0 cleared
        vecs[2].name = "branch  ";
        vecs[2].prog[0] = br(3'b000, 1, 1, 8);
        vecs[2].prog[1] = addi(6, 0, 1);
        vecs[2].prog[2] = br(3'b001, 0, 0, 8);
        vecs[2].prog[3] = jal(1, 16);
        vecs[2].prog[4] = sw(1, 32, 0);
        vecs[2].prog[7] = addi(1, 1, 1);
        vecs[2].prog[8] = jalr(0, 1, 0);
        vecs[2].run = 8'd50; vecs[2].exp_pc = 32'h114; vecs[2].exp_trap = 1'b1;
        vecs[2].exp_nret = 8'd6; vecs[2].ret_k = 8'd6; vecs[2].ret_cyc = 8'd22;
        vecs[2].n_chk = 2'd1; vecs[2].chk_w[0] = 8'd8; vecs[2].exp_w[0] = 32'h111;
        // x0 write discarded, then misaligned lw traps in EXEC
        vecs[3].name = "x0_misal";
        vecs[3].prog[0] = addi(0, 0, 7);
        vecs[3].prog[1] = sw(0, 40, 0);
        vecs[3].prog[2] = lw(7, 2, 0);
        vecs[3].run = 8'd30; vecs[3].exp_pc = 32'h108; vecs[3].exp_trap = 1'b1;
        vecs[3].exp_nret = 8'd2; vecs[3].ret_k = 8'd2; vecs[3].ret_cyc = 8'd8;
        vecs[3].n_chk = 2'd1; vecs[3].chk_w[0] = 8'd10; vecs[3].exp_w[0] = 32'd0;
        // opcode 0 traps before anything retires
        vecs[4].name = "illegal ";
        vecs[4].run = 8'd20; vecs[4].exp_pc = 32'h100; vecs[4].exp_trap = 1'b1;
        // add x17 runs on the RV32I core and traps on the RV32E core
        vecs[5].name = "rv32e   ";
        vecs[5].prog[0] = addi(1, 0, 5);
        vecs[5].prog[1] = addi(2, 0, 7);
        vecs[5].prog[2] = r_type(7'b0000000, 2, 1, 3'b000, 17);
        vecs[5].prog[3] = sw(17, 44, 0);
        vecs[5].run = 8'd40; vecs[5].exp_pc = 32'h110; vecs[5].exp_trap = 1'b1;
        vecs[5].exp_nret = 8'd4; vecs[5].ret_k = 8'd4; vecs[5].ret_cyc = 8'd16;
        vecs[5].n_chk = 2'd1; vecs[5].chk_w[0] = 8'd11; vecs[5].exp_w[0] = 32'd12;
        vecs[5].chk_e = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset state, first fetch address, then reset during a waited fetch
        load(vecs[1]);
        waits = 3;
        ret_k = 6;
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst req", 32'(mem_req), 32'd0);
        chk("rst pc", pc, 32'h100);
        chk("rst trap", 32'(trap), 32'd0);
        chk("rst retire", 32'(retire), 32'd0);
        release_reset();
        chk("first req", 32'(mem_req), 32'd1);
        chk("first addr", mem_addr, 32'h100);
        chk("first we", 32'(mem_we), 32'd0);
        repeat (8) cyc();
        chk("mid fetch addr", mem_addr, 32'h104);
        chk("mid fetch req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        drive_mem();
        cyc();
        chk("abort req", 32'(mem_req), 32'd0);
        chk("abort pc", pc, 32'h100);
        cyc();
        release_reset();
        chk("restart addr", mem_addr, 32'h100);
        chk("restart req", 32'(mem_req), 32'd1);
        repeat (100) cyc();
        chk("restart latency", ret_cyc, 32'd49);
        chk("restart pc", pc, 32'h120);
        chk("restart mem[4]", mem[4], 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
